// File: rtl/exs_pkg.sv
// exs_pkg: shared types, constants and range helper for the exs_inv decoder
package exs_pkg;

    typedef enum logic [1:0] {IDLE, DIV, CHECK, DONE} state_t;

    localparam int EXT_GUARD    = 4;
    localparam int MAX_ATTEMPTS = 3;

    function automatic logic fits_signed(input logic signed [63:0] v, input int w);
        return v >= -(64'sd1 <<< (w - 1)) && v <= (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/exs_inv_if.sv
// exs_inv_if: request/response handshake bundle of the exs_inv decoder
interface exs_inv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                         valid_i;
    logic                         ready_o;
    logic signed [DATA_WIDTH-1:0] q_i;
    logic signed [DATA_WIDTH-1:0] b_i;
    logic signed [DATA_WIDTH-1:0] c_i;
    logic signed [DATA_WIDTH-1:0] d_i;
    logic                         valid_o;
    logic                         ready_i;
    logic signed [DATA_WIDTH-1:0] a_o;
    logic                         inexact_o;
    logic                         ovf_o;

    modport slave (
        input  valid_i, q_i, b_i, c_i, d_i, ready_i,
        output ready_o, valid_o, a_o, inexact_o, ovf_o
    );

    modport master (
        output valid_i, q_i, b_i, c_i, d_i, ready_i,
        input  ready_o, valid_o, a_o, inexact_o, ovf_o
    );
endinterface

// File: rtl/exs_div_seq.sv
// exs_div_seq: unsigned restoring divider, one quotient bit per cycle
module exs_div_seq #(
    parameter int WIDTH = 36
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   trial;

    assign trial = {remainder, quotient[WIDTH-1]} - {1'b0, dvs};
    assign done  = busy && cnt == '0;

    // shift one dividend bit into the remainder per cycle, keep it only if the subtraction does not borrow
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            busy      <= 1'b0;
            cnt       <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= LAST;
            dvs       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (busy) begin
            remainder <= trial[WIDTH] ? {remainder[WIDTH-2:0], quotient[WIDTH-1]} : trial[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], ~trial[WIDTH]};
            cnt       <= cnt - 1'b1;
            busy      <= cnt != '0;
        end
    end
endmodule

// File: rtl/exs_inv.sv
// exs_inv: recovers a from q = ((a-b)*(3c+1) - 4d)/2 by retrying exact divisions
module exs_inv
    import exs_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic      clk_i,
    input logic      rstn_i,
    exs_inv_if.slave bus
);
    localparam int W_EXT = DATA_WIDTH + EXT_GUARD;
    typedef logic signed [W_EXT-1:0] ext_t;

    state_t                       state;
    ext_t                         p0, p_cur, den, b_ext;
    ext_t                         cx, qx, dx, in_den, in_p0, next_p, start_p, quo_s, a_ext;
    logic [W_EXT-1:0]             dividend, divisor, quo, rem;
    logic [1:0]                   attempt;
    logic                         q_neg, q_zero, accept, exact, more;
    logic                         div_start, div_busy, div_done;
    logic signed [DATA_WIDTH-1:0] a_r;
    logic                         inexact_r, ovf_r;

    assign accept    = bus.valid_i && state == IDLE;
    assign cx        = ext_t'(bus.c_i);
    assign qx        = ext_t'(bus.q_i);
    assign dx        = ext_t'(bus.d_i);
    assign in_den    = (cx <<< 1) + cx + ext_t'(1);
    assign in_p0     = (qx <<< 1) + (dx <<< 2);
    assign next_p    = attempt == 2'd0 ? p0 + (q_neg ? -ext_t'(1) : ext_t'(1)) : p0 - ext_t'(1);
    assign start_p   = accept ? in_p0 : next_p;
    assign dividend  = start_p[W_EXT-1] ? -start_p : start_p;
    assign divisor   = accept ? (in_den[W_EXT-1] ? -in_den : in_den) : (den[W_EXT-1] ? -den : den);
    assign quo_s     = (p_cur[W_EXT-1] ^ den[W_EXT-1]) ? -ext_t'(quo) : ext_t'(quo);
    assign a_ext     = b_ext + quo_s;
    assign exact     = rem == '0;
    assign more      = int'(attempt) + 1 < (q_zero ? MAX_ATTEMPTS : MAX_ATTEMPTS - 1);
    assign div_start = accept || (state == CHECK && !div_busy && !exact && more);

    assign bus.ready_o   = state == IDLE;
    assign bus.valid_o   = state == DONE;
    assign bus.a_o       = a_r;
    assign bus.inexact_o = inexact_r;
    assign bus.ovf_o     = ovf_r;

    exs_div_seq #(.WIDTH(W_EXT)) u_div (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .start     (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    // attempt sequencer: latch operands, run divisions until one is exact or attempts run out
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            p0        <= '0;
            p_cur     <= '0;
            den       <= '0;
            b_ext     <= '0;
            q_neg     <= 1'b0;
            q_zero    <= 1'b0;
            attempt   <= '0;
            a_r       <= '0;
            inexact_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    p0      <= in_p0;
                    p_cur   <= in_p0;
                    den     <= in_den;
                    b_ext   <= ext_t'(bus.b_i);
                    q_neg   <= bus.q_i[DATA_WIDTH-1];
                    q_zero  <= bus.q_i == '0;
                    attempt <= '0;
                    state   <= DIV;
                end
                DIV: if (div_done) state <= CHECK;
                CHECK: if (!div_busy) begin
                    if (exact) begin
                        if (fits_signed(64'(a_ext), DATA_WIDTH)) a_r <= a_ext[DATA_WIDTH-1:0];
                        else ovf_r <= 1'b1;
                        state <= DONE;
                    end else if (more) begin
                        attempt <= attempt + 1'b1;
                        p_cur   <= next_p;
                        state   <= DIV;
                    end else begin
                        inexact_r <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (bus.ready_i) begin
                    a_r       <= '0;
                    inexact_r <= 1'b0;
                    ovf_r     <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exs_inv.sv
// tb_exs_inv: scoreboard bench for exs_inv against an arithmetic reference model
module tb_exs_inv;
    localparam int DW    = 32;
    localparam int W_EXT = DW + 4;
    localparam int LAT0  = W_EXT + 2;
    localparam int LATN  = W_EXT + 1;

    typedef struct {
        longint a;
        longint inx;
        longint ovf;
        longint lat;
        longint acc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rstn;
    longint cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    int     n;
    exp_t   exp_q[$];

    exs_inv_if #(.DATA_WIDTH(DW)) bus ();

    exs_inv #(.DATA_WIDTH(DW)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int q, input int b, input int c, input int d);
        exp_t   r;
        longint den, p0, a;
        longint ps[$];
        bit     hit;
        den = 3 * longint'(c) + 1;
        p0  = 2 * longint'(q) + 4 * longint'(d);
        ps.push_back(p0);
        ps.push_back(p0 + (q < 0 ? -1 : 1));
        if (q == 0) ps.push_back(p0 - 1);
        r.a   = 0;
        r.inx = 1;
        r.ovf = 0;
        r.acc = 0;
        r.lat = LAT0 + LATN * (ps.size() - 1);
        hit   = 0;
        for (int i = 0; i < ps.size(); i++) begin
            if (!hit && ps[i] % den == 0) begin
                hit   = 1;
                a     = longint'(b) + ps[i] / den;
                r.inx = 0;
                r.lat = LAT0 + LATN * i;
                if (a > 64'sd2147483647 || a < -64'sd2147483648) r.ovf = 1;
                else r.a = a;
            end
        end
        return r;
    endfunction

    // drive a request at posedge+2 and hold it until the accept edge has passed
    task automatic send(input int q, input int b, input int c, input int d, input bit push, output int waits);
        exp_t e;
        waits       = 0;
        bus.q_i     = q;
        bus.b_i     = b;
        bus.c_i     = c;
        bus.d_i     = d;
        bus.valid_i = 1'b1;
        while (!bus.ready_o && waits < 300) begin
            @(posedge clk);
            #2;
            waits++;
        end
        if (!bus.ready_o) begin
            chk("accept_timeout", bus.ready_o, 1);
            bus.valid_i = 1'b0;
            return;
        end
        e     = model(q, b, c, d);
        e.acc = cyc + 1;
        @(posedge clk);
        #2;
        bus.valid_i = 1'b0;
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("result_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // monitor: compare every presented result with the head of the scoreboard
    initial begin
        bit   seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.valid_o) begin
                if (exp_q.size() == 0) chk("unexpected_valid", bus.valid_o, 0);
                else begin
                    e = exp_q[0];
                    if (!seen) begin
                        chk("latency", cyc - e.acc + 1, e.lat);
                        seen = 1;
                    end
                    chk("a_o", bus.a_o, e.a);
                    chk("inexact_o", bus.inexact_o, e.inx);
                    chk("ovf_o", bus.ovf_o, e.ovf);
                    chk("ready_o_busy", bus.ready_o, 0);
                    if (bus.ready_i) begin
                        void'(exp_q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        int tbl[7][4] = '{
            '{0, 0, 0, 0},
            '{49004, 1, 255, 10},
            '{3, 0, 2, 0},
            '{-3, 0, 2, 0},
            '{0, 5, 2, 2},
            '{1, 0, 2, 0},
            '{1, 2147483647, 0, 0}
        };
        longint a, b, c, d, q;
        rstn        = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.q_i     = '0;
        bus.b_i     = '0;
        bus.c_i     = '0;
        bus.d_i     = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready_o", bus.ready_o, 1);
        chk("rst_valid_o", bus.valid_o, 0);
        chk("rst_a_o", bus.a_o, 0);
        chk("rst_inexact_o", bus.inexact_o, 0);
        chk("rst_ovf_o", bus.ovf_o, 0);
        rstn = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 7; i++) begin
            send(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], 1'b1, n);
            wait_done();
        end
        send(49004, 1, 255, 10, 1'b0, n);
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        rstn = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_mid_ready_o", bus.ready_o, 1);
        chk("rst_mid_valid_o", bus.valid_o, 0);
        chk("rst_mid_a_o", bus.a_o, 0);
        rstn = 1'b1;
        send(0, 5, 2, 2, 1'b1, n);
        wait_done();
        bus.ready_i = 1'b0;
        send(49004, 1, 255, 10, 1'b1, n);
        n = 0;
        while (!bus.valid_o && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("bp_valid_seen", bus.valid_o, 1);
        repeat (10) begin
            @(posedge clk);
            #2;
            bus.valid_i = 1'b1;
            bus.q_i     = $urandom;
            bus.b_i     = $urandom;
            bus.c_i     = $urandom;
            bus.d_i     = $urandom;
            chk("bp_ready_low", bus.ready_o, 0);
        end
        bus.ready_i = 1'b1;
        send(3, 0, 2, 0, 1'b1, n);
        chk("b2b_accept_wait", n, 1);
        wait_done();
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 3) begin
                send(int'($urandom), int'($urandom), int'($urandom), int'($urandom), 1'b1, n);
            end else begin
                a = longint'($urandom_range(65536)) - 32768;
                b = longint'($urandom_range(65536)) - 32768;
                c = longint'($urandom_range(2048)) - 1024;
                d = longint'($urandom_range(65536)) - 32768;
                q = ((a - b) * (3 * c + 1) - 4 * d) / 2;
                send(int'(q), int'(b), int'(c), int'(d), 1'b1, n);
            end
            if (i % 8 == 5) bus.ready_i = 1'b0;
            repeat (i % 3) @(posedge clk);
            #2;
            bus.ready_i = 1'b1;
        end
        wait_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/exs_inv.md
Name: exs_inv

Overview:
- Iterative inverse of the exs_of datapath. Forward function: q = ((a-b)*(3c+1) - 4d)/2, where "/" truncates toward zero.
- Given q, b, c and d, the block recovers an operand a that satisfies that equation.
- Sits beside exs_of as the reader/decoder end of the same arithmetic link.
- Valid/ready handshake on both sides; one request in flight at a time.

Parameters:
DATA_WIDTH, 32, width of q_i, b_i, c_i, d_i, a_o (signed two's complement)

Ports:
clk_i  in  1  clock, all logic on rising edge
rstn_i  in  1  reset, synchronous, active-low
valid_i  in  1  request valid
ready_o  out  1  block can accept a request (high only in IDLE)
q_i  in  DATA_WIDTH  forward result, signed
b_i  in  DATA_WIDTH  signed
c_i  in  DATA_WIDTH  signed
d_i  in  DATA_WIDTH  signed
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
a_o  out  DATA_WIDTH  recovered a, signed; 0 when any error flag is set
inexact_o  out  1  no attempt divided exactly
ovf_o  out  1  recovered a does not fit in DATA_WIDTH signed

Behaviour:
- Reset (rstn_i low at a clock edge):
  - state returns to IDLE; ready_o=1; valid_o=0; a_o=0; inexact_o=0; ovf_o=0; all counters cleared.
  - This applies in every state, including mid-division; the in-flight request is discarded.
- Widths: W_EXT = DATA_WIDTH+4. All internal arithmetic is sign-extended to W_EXT bits.
- Operands latched on the accept edge (valid_i && ready_o):
  - den = 3*c + 1. den is never 0 for integer c; no divide-by-zero path exists.
  - P0 = 2*q + 4*d.
- Attempt sequence (first exact attempt wins):
  - attempt 0: P0.
  - attempt 1: P0+s, where s=+1 if q>=0 and s=-1 if q<0.
  - attempt 2: P0-1, only when q==0.
  - Max attempts: 2 if q!=0, 3 if q==0.
- Division per attempt:
  - Signed truncating division: unsigned restoring divide on magnitudes, one quotient bit per cycle, W_EXT cycles.
  - Quotient sign = sign(P) xor sign(den).
  - Exact means remainder magnitude == 0.
- States:
  - IDLE: ready_o=1. On accept -> DIV, bit counter = W_EXT-1, attempt = 0.
  - DIV: W_EXT cycles. When the bit counter reaches 0 -> CHECK.
  - CHECK: 1 cycle.
    - If exact: a_ext = b + quotient. ovf_o = (a_ext outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]). -> DONE.
    - Else if attempts remain: attempt++, reload dividend -> DIV.
    - Else: inexact_o=1 -> DONE.
  - DONE: valid_o=1. a_o, inexact_o and ovf_o stay stable until ready_i is high at an edge, then -> IDLE and flags clear.
- Latency, from accept edge to first valid_o cycle: W_EXT+2 for attempt 0. Each further attempt adds W_EXT+1. For DATA_WIDTH=32 this gives 38 / 75 / 112 cycles.
- valid_i while busy is ignored; ready_o is low.
- ready_i is ignored outside DONE. ready_i held low stalls DONE indefinitely with outputs held.
- ovf_o and inexact_o are mutually exclusive. a_o=0 whenever either is set.

Decomposition:
- Package exs_pkg:
  - state enum typedef (IDLE, DIV, CHECK, DONE);
  - localparam EXT_GUARD=4;
  - localparam MAX_ATTEMPTS=3;
  - function for the signed range check.
- Sub-module exs_div_seq: unsigned iterative restoring divider.
  - Ports: start, dividend/divisor magnitudes, busy/done, quotient, remainder. Parameter WIDTH.
  - exs_inv owns sign handling, the attempt FSM and the handshakes.

Test Plan:
- Reset/zero: q=b=c=d=0 -> a_o=0, flags 0, valid_o at cycle 38. Reset held low during DIV -> IDLE next edge, ready_o=1, valid_o=0.
- Exact first attempt: q=49004, b=1, c=255, d=10 (P=98048, den=766) -> a_o=129, flags 0, latency 38.
- Odd-numerator retry: q=3, b=0, c=2, d=0 -> attempt 1 (P=7) -> a_o=1, latency 75. Negative case: q=-3 -> a_o=-1, latency 75.
- q==0 third attempt: q=0, b=5, c=2, d=2 (P=8, then 9, then 7) -> a_o=6, latency 112.
- Errors:
  - q=1, b=0, c=2, d=0 -> inexact_o=1, a_o=0, latency 75.
  - q=1, b=2^31-1, c=0, d=0 -> ovf_o=1, a_o=0, latency 38.
- Backpressure: hold ready_i=0 for 10 cycles in DONE -> outputs stable, ready_o=0, valid_i ignored. Release -> IDLE the next cycle; a back-to-back request is accepted.
